// File: rtl/mips_pkg.sv
// Shared IMEM geometry and byte-loader state encoding.
// Imported by the loader and by the IMEM array.
package mips_pkg;

  localparam int IMEM_DEPTH  = 128;
  localparam int IMEM_ADDR_W = 8;
  localparam int LD_CNT_W    = 6;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/imem_128x8_wr.sv
// 128x8 instruction memory: byte write port from the loader,
// combinational big-endian 32-bit fetch port.
module imem_128x8_wr
  import mips_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_wdata,
  input  logic [ADDR_W-1:0] read_address,
  output logic [31:0]       instruction
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [IDX_W-1:0] ra;
  logic             unused_hi;

  // Only the low index bits address the array.
  assign ra        = read_address[IDX_W-1:0];
  assign unused_hi = ^{mem_addr[ADDR_W-1:IDX_W],
                       read_address[ADDR_W-1:IDX_W]};

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[IDX_W-1:0]] <= mem_wdata;
    end
  end

  assign instruction = {mem[ra],
                        mem[ra + IDX_W'(1)],
                        mem[ra + IDX_W'(2)],
                        mem[ra + IDX_W'(3)]};

endmodule

// File: rtl/imem_byte_loader.sv
// Streams bytes into the IMEM write port, big-endian per word,
// and holds the core in stall until a full program is loaded.
module imem_byte_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int CNT_W  = LD_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              err
);

  localparam int TW = CNT_W + 2;

  ld_state_t         state;
  logic [ADDR_W-1:0] byte_ptr;
  logic [TW-1:0]     total;
  logic              legal;
  logic              beat;
  logic              last;

  assign legal = (word_count != '0) &&
                 (word_count <= CNT_W'(DEPTH / 4));
  assign rx_ready = (state == LD_LOAD);
  assign beat     = rx_valid & rx_ready;
  assign last     = (byte_ptr == ADDR_W'(total - TW'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LD_IDLE;
      byte_ptr  <= '0;
      total     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_hold  <= 1'b1;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        LD_IDLE: begin
          if (start && legal) begin
            state    <= LD_LOAD;
            busy     <= 1'b1;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
            byte_ptr <= '0;
            total    <= {word_count, 2'b00};
          end else if (start) begin
            err <= 1'b1;
          end
        end
        LD_LOAD: begin
          if (beat) begin
            mem_we    <= 1'b1;
            mem_addr  <= byte_ptr;
            mem_wdata <= rx_data;
            byte_ptr  <= byte_ptr + ADDR_W'(1);
            if (last) begin
              state <= LD_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        LD_DONE: begin
          // Core is released only once the final byte is in IMEM.
          state    <= LD_IDLE;
          cpu_hold <= 1'b0;
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule
